// File: rtl/usb_cdc_rx_packer.sv
// Packs bytes popped from a first-word-fall-through RX FIFO, LSB-first, into 32-bit words.
// A word is emitted when it is full, after a programmable idle time, or on flush; valid/ready out.
module usb_cdc_rx_packer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_fifo_empty,
  input  logic [7:0]      rx_fifo_rdata,
  output logic            rx_fifo_rd,
  input  logic [TO_W-1:0] timeout,
  input  logic            flush,
  output logic [31:0]     word_data,
  output logic [2:0]      word_bytes,
  output logic            word_valid,
  input  logic            word_ready
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [TO_W-1:0] r_idle;
  logic [31:0]     r_data;

  logic            w_pop;
  logic            w_expire;
  logic            w_idle_max;
  logic [TO_W:0]   w_idle_inc;

  // Gated by rst_n so the FIFO is never drained while this block is held in reset.
  assign w_pop      = rst_n & (r_state == COLLECT) & ~rx_fifo_empty & (r_cnt < 3'd4);
  assign w_idle_inc = {1'b0, r_idle} + (TO_W+1)'(1);
  assign w_expire   = (timeout != '0) && (w_idle_inc == {1'b0, timeout});
  assign w_idle_max = &r_idle;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: begin
        if (w_pop) begin
          if (r_cnt == 3'd3 || flush) w_state_nxt = HOLD;
        end else if (r_cnt != 3'd0 && (flush || w_expire)) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: if (word_ready) w_state_nxt = COLLECT;
    endcase
  end

  // NOTE: the data register is reset so unused lanes of a short word always read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 3'd0;
      r_idle <= '0;
      r_data <= 32'h0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_pop) begin
            r_data[{r_cnt[1:0], 3'b000} +: 8] <= rx_fifo_rdata;
            r_cnt  <= r_cnt + 3'd1;
            r_idle <= '0;
          end else if (r_cnt == 3'd0) begin
            r_idle <= '0;
          end else if (!w_idle_max) begin
            r_idle <= w_idle_inc[TO_W-1:0];
          end
        end
        HOLD: begin
          if (word_ready) begin
            r_cnt  <= 3'd0;
            r_idle <= '0;
            r_data <= 32'h0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rx_fifo_rd = w_pop;
    word_valid = (r_state == HOLD);
    word_bytes = (r_state == HOLD) ? r_cnt : 3'd0;
    word_data  = r_data;
  end

endmodule

// File: tb/tb_usb_cdc_rx_packer.sv
// Directed bench for usb_cdc_rx_packer: FIFO model drives the DUT, a scoreboard queue
// holds the expected words and a monitor compares every accepted word.
module tb_usb_cdc_rx_packer;
  localparam int TO_W = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_fifo_empty = 1'b1;
  logic [7:0]      rx_fifo_rdata = 8'h00;
  logic            rx_fifo_rd;
  logic [TO_W-1:0] timeout = '0;
  logic            flush = 1'b0;
  logic [31:0]     word_data;
  logic [2:0]      word_bytes;
  logic            word_valid;
  logic            word_ready = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] fifo_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pop_count = 0;
  int         accepts = 0;
  logic       pop_seen;

  usb_cdc_rx_packer #(.TO_W(TO_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_rdata (rx_fifo_rdata),
    .rx_fifo_rd    (rx_fifo_rd),
    .timeout       (timeout),
    .flush         (flush),
    .word_data     (word_data),
    .word_bytes    (word_bytes),
    .word_valid    (word_valid),
    .word_ready    (word_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    rx_fifo_empty = (fifo_q.size() == 0);
    rx_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
    exp_t e;
    e.data  = d;
    e.bytes = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // FWFT FIFO model: rd is sampled before the edge updates DUT state, the pop lands just after.
  always @(posedge clk) begin
    pop_seen = rx_fifo_rd;
    #1;
    if (pop_seen) begin
      check("rd_while_empty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pop_count++;
      end
      refresh();
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && word_valid && word_ready) begin
      accepts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=0x%0h bytes=%0d, none expected", word_data, word_bytes);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", word_data, mon_e.data);
        check("word_bytes", 32'(word_bytes), 32'(mon_e.bytes));
      end
    end else if (rst_n && !word_valid) begin
      check("bytes_when_idle", 32'(word_bytes), 32'd0);
    end
  end

  initial begin
    int p0;
    int a0;
    int lat;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_bytes", 32'(word_bytes), 32'd0);
    check("rst_data",  word_data,       32'h0);
    check("rst_rd",    32'(rx_fifo_rd), 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Full 4-byte word
    p0 = pop_count;
    a0 = accepts;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_word(32'h44332211, 3'd4);
    wait_cycles(8);
    check("full_pops", 32'(pop_count - p0), 32'd4);
    check("full_accepts", 32'(accepts - a0), 32'd1);

    // Idle timeout of 10 cycles after a single byte
    timeout = 16'd10;
    push(8'h5A);
    expect_word(32'h0000005A, 3'd1);
    @(posedge clk);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 50 && !found; k++) begin
      @(posedge clk);
      #1;
      if (word_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    check("timeout10_latency", 32'(lat), 32'd10);
    wait_cycles(3);

    // Timeout disabled: no word for 1000 cycles, then flush it out
    timeout = '0;
    a0 = accepts;
    push(8'h5A);
    wait_cycles(1000);
    check("no_timeout_valid", 32'(word_valid), 32'd0);
    check("no_timeout_accepts", 32'(accepts - a0), 32'd0);
    expect_word(32'h0000005A, 3'd1);
    pulse_flush();
    wait_cycles(4);

    // Explicit flush of a 2-byte partial word, then flush with nothing collected
    push(8'hA1); push(8'hB2);
    wait_cycles(3);
    expect_word(32'h0000B2A1, 3'd2);
    pulse_flush();
    wait_cycles(4);
    a0 = accepts;
    pulse_flush();
    wait_cycles(10);
    check("empty_flush_valid", 32'(word_valid), 32'd0);
    check("empty_flush_accepts", 32'(accepts - a0), 32'd0);

    // Back-pressure: first word held, FIFO keeps the remaining 4 bytes
    word_ready = 1'b0;
    a0 = accepts;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h04030201, 3'd4);
    expect_word(32'h08070605, 3'd4);
    wait_cycles(12);
    check("hold_valid", 32'(word_valid), 32'd1);
    check("hold_data",  word_data,       32'h04030201);
    check("hold_bytes", 32'(word_bytes), 32'd4);
    check("hold_rd",    32'(rx_fifo_rd), 32'd0);
    check("hold_fifo_level", 32'(fifo_q.size()), 32'd4);
    word_ready = 1'b1;
    wait_cycles(10);
    check("backpressure_accepts", 32'(accepts - a0), 32'd2);

    // Timeout of 3: a byte arriving on the expiring cycle wins and restarts the timer
    timeout = 16'd3;
    push(8'h01);
    expect_word(32'h00000201, 3'd2);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("race_not_emitted", 32'(word_valid), 32'd0);
    push(8'h02);
    @(posedge clk);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (word_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    check("race_restart_latency", 32'(lat), 32'd3);
    wait_cycles(4);
    timeout = '0;

    // Reset mid-word discards the partial word; packing restarts from lane 0
    push(8'hC1); push(8'hC2);
    wait_cycles(3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_bytes", 32'(word_bytes), 32'd0);
    check("midrst_data",  word_data,       32'h0);
    check("midrst_rd",    32'(rx_fifo_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    expect_word(32'hD4D3D2D1, 3'd4);
    wait_cycles(8);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
